// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: core-side request/response bus plus the shared data-memory port of dm_arbiter
interface dm_arbiter_if #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [NUM_CORES-1:0] req, we, gnt, done;
    logic [NUM_CORES*ADDR_W-1:0] addr;
    logic [NUM_CORES*DATA_W-1:0] wdata, rdata;
    logic busy, mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter sharing one data-memory port among NUM_CORES cores
module dm_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int MEM_LAT = 1
) (
    input logic clk,
    input logic rst_n,
    dm_arbiter_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_CORES);
    localparam int LAT_W = $clog2(MEM_LAT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state;
    logic [SEL_W-1:0] sel, rr_ptr, nxt;
    logic [LAT_W-1:0] lat_cnt;
    logic l_we, found;
    // descending scan so the lowest offset from rr_ptr wins
    always_comb begin
        found = 1'b0;
        nxt = rr_ptr;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (bus.req[(int'(rr_ptr) + k) % NUM_CORES]) begin
                found = 1'b1;
                nxt = SEL_W'((int'(rr_ptr) + k) % NUM_CORES);
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rr_ptr <= '0;
            lat_cnt <= '0;
            sel <= '0;
            l_we <= 1'b0;
            bus.gnt <= '0;
            bus.done <= '0;
            bus.busy <= 1'b0;
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_wdata <= '0;
            bus.rdata <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    state <= ISSUE;
                    sel <= nxt;
                    l_we <= bus.we[nxt];
                    bus.gnt <= NUM_CORES'(1) << nxt;
                    bus.busy <= 1'b1;
                    bus.mem_en <= 1'b1;
                    bus.mem_we <= bus.we[nxt];
                    bus.mem_addr <= bus.addr[int'(nxt)*ADDR_W +: ADDR_W];
                    bus.mem_wdata <= bus.wdata[int'(nxt)*DATA_W +: DATA_W];
                end
                ISSUE: begin
                    state <= WAIT;
                    bus.gnt <= '0;
                    bus.mem_en <= 1'b0;
                    bus.mem_we <= 1'b0;
                    lat_cnt <= LAT_W'(MEM_LAT - 1);
                end
                WAIT: if (lat_cnt == '0) begin
                    state <= RESP;
                    bus.done <= NUM_CORES'(1) << sel;
                    if (!l_we) bus.rdata[int'(sel)*DATA_W +: DATA_W] <= bus.mem_rdata;
                end else begin
                    lat_cnt <= lat_cnt - 1'b1;
                end
                RESP: begin
                    state <= IDLE;
                    bus.done <= '0;
                    bus.busy <= 1'b0;
                    rr_ptr <= (sel == SEL_W'(NUM_CORES - 1)) ? '0 : sel + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
